// File: rtl/cpu_pkg.sv
// Shared RV32I encodings, ALU operation set and decode control bundle
// used by the single-cycle core.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    a_pc;
    logic    b_imm;
    logic    reg_wr;
    wb_sel_e wb_sel;
    logic    mem_wr;
    logic    branch;
    logic    jal;
    logic    jalr;
  } ctrl_t;

  // Default decode: behaves as a NOP (PC+4, no writes).
  localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, a_pc: 1'b0, b_imm: 1'b0,
                                 reg_wr: 1'b0, wb_sel: WB_ALU, mem_wr: 1'b0,
                                 branch: 1'b0, jal: 1'b0, jalr: 1'b0};

  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cpu_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous
// write port, x0 hard-wired to zero.
module reg_file (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] registers [32];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      registers[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : registers[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : registers[rs2_addr];

endmodule

// File: rtl/cpu.sv
// Single-cycle RV32I core: fetch, decode, execute and retire one
// instruction per clock. Word-only data memory; reset is active-high.
module cpu
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instruction,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_sig,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mem_addr,
  output logic [31:0] rom_addr
);

  logic [31:0] pc, pc_plus4, pc_target, next_pc;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, alu_imm;
  logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_y, agu_sum, wb_data;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        imm_ok, reg_ok, taken;
  ctrl_t       ctrl;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Reject encodings outside RV32I (e.g. M-extension funct7) so they retire as NOP.
  assign imm_ok = !(funct3 == F3_SLL && funct7 != F7_BASE) &&
                  !(funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT);
  assign reg_ok = (funct7 == F7_BASE) ||
                  (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));

  always_comb begin
    ctrl    = CTRL_NOP;
    alu_imm = imm_i;
    case (opcode)
      OP_LUI: begin
        ctrl.alu_op = ALU_PASS_B;
        ctrl.b_imm  = 1'b1;
        ctrl.reg_wr = 1'b1;
        alu_imm     = imm_u;
      end
      OP_AUIPC: begin
        ctrl.a_pc   = 1'b1;
        ctrl.b_imm  = 1'b1;
        ctrl.reg_wr = 1'b1;
        alu_imm     = imm_u;
      end
      OP_JAL: begin
        ctrl.jal    = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.wb_sel = WB_PC4;
      end
      OP_JALR: begin
        ctrl.jalr   = 1'b1;
        ctrl.reg_wr = 1'b1;
        ctrl.wb_sel = WB_PC4;
      end
      OP_BRANCH: ctrl.branch = 1'b1;
      OP_LOAD: begin
        ctrl.reg_wr = 1'b1;
        ctrl.wb_sel = WB_MEM;
      end
      OP_STORE: ctrl.mem_wr = 1'b1;
      OP_IMM: begin
        if (imm_ok) begin
          ctrl.alu_op = alu_decode(funct3, funct3 == F3_SR && funct7[5]);
          ctrl.b_imm  = 1'b1;
          ctrl.reg_wr = 1'b1;
        end
      end
      OP_REG: begin
        if (reg_ok) begin
          ctrl.alu_op = alu_decode(funct3, funct7[5]);
          ctrl.reg_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign alu_a = ctrl.a_pc  ? pc      : rs1_val;
  assign alu_b = ctrl.b_imm ? alu_imm : rs2_val;

  always_comb begin
    alu_y = '0;
    case (ctrl.alu_op)
      ALU_ADD:    alu_y = alu_a + alu_b;
      ALU_SUB:    alu_y = alu_a - alu_b;
      ALU_SLL:    alu_y = alu_a << alu_b[4:0];
      ALU_SLT:    alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   alu_y = {31'b0, alu_a < alu_b};
      ALU_XOR:    alu_y = alu_a ^ alu_b;
      ALU_SRL:    alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:    alu_y = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:     alu_y = alu_a | alu_b;
      ALU_AND:    alu_y = alu_a & alu_b;
      ALU_PASS_B: alu_y = alu_b;
      default:    alu_y = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val <  rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // One adder serves both the load/store address and the JALR target.
  assign agu_sum   = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + (ctrl.jal ? imm_j : imm_b);

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl.jalr)
      next_pc = {agu_sum[31:1], 1'b0};
    else if (ctrl.jal || (ctrl.branch && taken))
      next_pc = pc_target;
  end

  always_comb begin
    case (ctrl.wb_sel)
      WB_MEM:  wb_data = mem_rd_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) pc <= RESET_PC;
    else         pc <= next_pc;
  end

  reg_file reg_file_inst (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (ctrl.reg_wr & ~reset_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .rd_data  (wb_data),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val)
  );

  assign rom_addr    = pc;
  assign mem_addr    = agu_sum;
  assign mem_wr_data = rs2_val;
  assign mem_wr_sig  = ctrl.mem_wr & ~reset_n;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed programs plus random instruction
// streams, compared in lockstep against an instruction-level model.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] instruction, mem_rd_data, mem_wr_data, mem_addr, rom_addr;
  logic        mem_wr_sig;

  cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instruction (instruction),
    .mem_rd_data (mem_rd_data),
    .mem_wr_sig  (mem_wr_sig),
    .mem_wr_data (mem_wr_data),
    .mem_addr    (mem_addr),
    .rom_addr    (rom_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [1024];
  assign instruction = imem[rom_addr[9:2]];
  assign mem_rd_data = dmem[mem_addr[11:2]];
  always @(posedge clk) if (mem_wr_sig) dmem[mem_addr[11:2]] <= mem_wr_data;

  // Instruction-level reference model state
  logic [31:0] mregs [32];
  logic [31:0] mdmem [1024];
  logic [31:0] mpc;

  int n_checks = 0;
  int n_fail = 0;
  int st_cnt;
  logic [31:0] st_last_addr;
  logic [31:0] pc_trace [$];

  function automatic logic [31:0] e_i(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_s(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] e_u(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
  endtask

  // Executes the instruction at mpc per the ISA rules; reports any store.
  task automatic model_step(output bit st, output logic [31:0] sa, output logic [31:0] sd);
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, v, nxt, ea;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit          wr, tk;
    ins = imem[mpc[9:2]];
    rd = ins[11:7];
    f3 = ins[14:12];
    a  = mregs[ins[19:15]];
    b  = mregs[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = mpc + 32'd4; wr = 0; tk = 0; v = '0; st = 0; sa = '0; sd = '0;
    case (ins[6:0])
      7'h37: begin wr = 1; v = iu; end
      7'h17: begin wr = 1; v = mpc + iu; end
      7'h6f: begin wr = 1; v = mpc + 32'd4; nxt = mpc + ij; end
      7'h67: begin wr = 1; v = mpc + 32'd4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 0;
        endcase
        if (tk) nxt = mpc + ib;
      end
      7'h03: begin ea = a + ii; wr = 1; v = mdmem[ea[11:2]]; end
      7'h23: begin ea = a + is; st = 1; sa = ea; sd = b; mdmem[ea[11:2]] = b; end
      7'h13, 7'h33: begin
        wr = 1;
        if (ins[5] == 1'b0) b = ii;
        case (f3)
          3'd0: v = (ins[5] && ins[30]) ? a - b : a + b;
          3'd1: v = a << b[4:0];
          3'd2: v = {31'b0, $signed(a) < $signed(b)};
          3'd3: v = {31'b0, a < b};
          3'd4: v = a ^ b;
          3'd5: v = ins[30] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: v = a | b;
          default: v = a & b;
        endcase
      end
      default: ;
    endcase
    if (wr && rd != 5'd0) mregs[rd] = v;
    mpc = nxt;
  endtask

  // Asserts reset with fresh memories; returns at a negedge just after release.
  task automatic do_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin dmem[i] = '0; mdmem[i] = '0; end
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b0;
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endtask

  // Lockstep runner, entered at a negedge. Stops before executing halt_pc,
  // or before the (stop_sw)th store (0-based) when stop_sw >= 0.
  task automatic run_prog(input int max_cyc, input logic [31:0] halt_pc,
                          input int stop_sw, output int used);
    bit est;
    logic [31:0] ea, ed;
    int seen;
    seen = 0; used = 0; st_cnt = 0; st_last_addr = '0;
    pc_trace.delete();
    for (int c = 0; c < max_cyc; c++) begin
      if (mpc == halt_pc) return;
      if (imem[mpc[9:2]][6:0] == 7'h23) begin
        if (seen == stop_sw) return;
        seen++;
      end
      pc_trace.push_back(rom_addr);
      n_checks++;
      if (rom_addr !== mpc) begin
        n_fail++;
        $display("FAIL pc cycle %0d: got %h want %h", c, rom_addr, mpc);
      end
      model_step(est, ea, ed);
      n_checks++;
      if (mem_wr_sig !== est || (est && (mem_addr !== ea || mem_wr_data !== ed))) begin
        n_fail++;
        $display("FAIL store cycle %0d: got sig=%b addr=%h data=%h want sig=%b addr=%h data=%h",
                 c, mem_wr_sig, mem_addr, mem_wr_data, est, ea, ed);
      end
      if (mem_wr_sig === 1'b1) begin st_cnt++; st_last_addr = mem_addr; end
      used++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load_sum();
    clear_imem();
    imem[0]  = e_i(7'h13, 3'd0, 5'd2, 5'd0, 12'h400);
    imem[1]  = e_i(7'h13, 3'd0, 5'd10, 5'd0, 12'd10);
    imem[2]  = e_j(5'd1, 21'd12);
    imem[3]  = e_i(7'h13, 3'd0, 5'd29, 5'd10, 12'd0);
    imem[4]  = e_j(5'd0, 21'd0);
    imem[5]  = e_b(3'd1, 5'd10, 5'd0, 13'd8);
    imem[6]  = e_i(7'h67, 3'd0, 5'd0, 5'd1, 12'd0);
    imem[7]  = e_i(7'h13, 3'd0, 5'd2, 5'd2, 12'hFF8);
    imem[8]  = e_s(3'd2, 5'd2, 5'd1, 12'd4);
    imem[9]  = e_s(3'd2, 5'd2, 5'd10, 12'd0);
    imem[10] = e_i(7'h13, 3'd0, 5'd10, 5'd10, 12'hFFF);
    imem[11] = e_j(5'd1, 21'h1FFFE8);
    imem[12] = e_i(7'h03, 3'd2, 5'd5, 5'd2, 12'd0);
    imem[13] = e_i(7'h03, 3'd2, 5'd1, 5'd2, 12'd4);
    imem[14] = e_i(7'h13, 3'd0, 5'd2, 5'd2, 12'd8);
    imem[15] = e_r(7'h00, 3'd0, 5'd10, 5'd10, 5'd5);
    imem[16] = e_i(7'h67, 3'd0, 5'd0, 5'd1, 12'd0);
  endtask

  task automatic test_reset();
    clear_imem();
    imem[0] = e_s(3'd2, 5'd0, 5'd0, 12'd0);
    reset_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (mem_wr_sig !== 1'b0) begin n_fail++; $display("FAIL reset_store_gate: got %b want 0", mem_wr_sig); end
    n_checks++;
    if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", rom_addr); end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.reg_file_inst.registers[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_reg x%0d: got %h want 0", i, dut.reg_file_inst.registers[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_wr_sig !== 1'b1 || rom_addr !== 32'h0) begin
      n_fail++; $display("FAIL post_release: got sig=%b pc=%h want 1 0", mem_wr_sig, rom_addr);
    end
  endtask

  task automatic test_alu_mem();
    int used;
    clear_imem();
    imem[0] = e_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5);
    imem[1] = e_i(7'h13, 3'd0, 5'd2, 5'd1, 12'hFF9);
    imem[2] = e_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd9);
    imem[3] = e_r(7'h20, 3'd0, 5'd3, 5'd0, 5'd1);
    imem[4] = e_s(3'd2, 5'd0, 5'd1, 12'd8);
    imem[5] = e_i(7'h03, 3'd2, 5'd4, 5'd0, 12'd8);
    imem[6] = e_j(5'd0, 21'd0);
    do_reset();
    run_prog(2, 32'hFFFF_FFFF, -1, used);
    n_checks++;
    if (dut.reg_file_inst.registers[1] !== 32'd5 || dut.reg_file_inst.registers[2] !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL addi_pair: got x1=%h x2=%h want 5 fffffffe",
                         dut.reg_file_inst.registers[1], dut.reg_file_inst.registers[2]);
    end
    mpc = rom_addr;
    run_prog(20, 32'h18, -1, used);
    n_checks++;
    if (dut.reg_file_inst.registers[0] !== 32'h0) begin n_fail++; $display("FAIL x0_write: got %h want 0", dut.reg_file_inst.registers[0]); end
    n_checks++;
    if (dut.reg_file_inst.registers[3] !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL sub: got %h want fffffffb", dut.reg_file_inst.registers[3]); end
    n_checks++;
    if (st_cnt != 1 || st_last_addr !== 32'd8) begin n_fail++; $display("FAIL sw_strobe: got cnt=%0d addr=%h want 1 8", st_cnt, st_last_addr); end
    n_checks++;
    if (dut.reg_file_inst.registers[4] !== 32'd5 || dmem[2] !== 32'd5) begin
      n_fail++; $display("FAIL lw: got x4=%h mem=%h want 5 5", dut.reg_file_inst.registers[4], dmem[2]);
    end
  endtask

  task automatic test_branch_jal();
    int used;
    logic [31:0] exp_pc [7];
    exp_pc = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h1C, 32'h20};
    clear_imem();
    imem[0]  = e_i(7'h13, 3'd0, 5'd1, 5'd0, 12'hFFF);
    imem[1]  = e_i(7'h13, 3'd0, 5'd2, 5'd0, 12'd1);
    imem[2]  = e_b(3'd4, 5'd1, 5'd2, 13'd8);
    imem[3]  = e_i(7'h13, 3'd0, 5'd5, 5'd0, 12'd99);
    imem[4]  = e_b(3'd6, 5'd1, 5'd2, 13'd8);
    imem[5]  = e_b(3'd0, 5'd2, 5'd2, 13'd8);
    imem[6]  = e_i(7'h13, 3'd0, 5'd6, 5'd0, 12'd77);
    imem[7]  = e_b(3'd0, 5'd1, 5'd2, 13'd100);
    imem[8]  = e_j(5'd1, 21'd16);
    imem[9]  = e_i(7'h13, 3'd0, 5'd7, 5'd0, 12'd55);
    imem[10] = e_i(7'h13, 3'd0, 5'd7, 5'd0, 12'd55);
    imem[11] = e_i(7'h13, 3'd0, 5'd7, 5'd0, 12'd55);
    imem[12] = e_j(5'd0, 21'd0);
    do_reset();
    run_prog(20, 32'h30, -1, used);
    n_checks++;
    if (pc_trace.size() != 7) begin n_fail++; $display("FAIL branch_len: got %0d want 7", pc_trace.size()); end
    for (int i = 0; i < 7 && i < pc_trace.size(); i++) begin
      n_checks++;
      if (pc_trace[i] !== exp_pc[i]) begin n_fail++; $display("FAIL branch_pc[%0d]: got %h want %h", i, pc_trace[i], exp_pc[i]); end
    end
    n_checks++;
    if (rom_addr !== 32'h30 || dut.reg_file_inst.registers[1] !== 32'h24) begin
      n_fail++; $display("FAIL jal: got pc=%h x1=%h want 30 24", rom_addr, dut.reg_file_inst.registers[1]);
    end
    n_checks++;
    if (dut.reg_file_inst.registers[5] !== 0 || dut.reg_file_inst.registers[6] !== 0 ||
        dut.reg_file_inst.registers[7] !== 0) begin
      n_fail++; $display("FAIL skipped: got x5=%h x6=%h x7=%h want 0", dut.reg_file_inst.registers[5],
                         dut.reg_file_inst.registers[6], dut.reg_file_inst.registers[7]);
    end
  endtask

  task automatic test_sum_recursive();
    int used;
    load_sum();
    do_reset();
    run_prog(500, 32'h10, -1, used);
    n_checks++;
    if (mpc !== 32'h10) begin n_fail++; $display("FAIL sum_timeout: got pc=%h want 10 within 500", mpc); end
    n_checks++;
    if (dut.reg_file_inst.registers[29] !== 32'd55) begin n_fail++; $display("FAIL sum: got %0d want 55", dut.reg_file_inst.registers[29]); end
  endtask

  function automatic logic [31:0] rand_ins(input int idx);
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  nop_ops [3];
    nop_ops = '{7'h0F, 7'h73, 7'h0B};
    r = $urandom();
    rd = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1: begin
        if (f3 == 3'd1) return e_i(7'h13, f3, rd, rs1, {7'b0, r[4:0]});
        if (f3 == 3'd5) return e_i(7'h13, f3, rd, rs1, {1'b0, r[30], 5'b0, r[4:0]});
        return e_i(7'h13, f3, rd, rs1, r[31:20]);
      end
      2, 3: return e_r((r[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00, f3, rd, rs1, rs2);
      4: return e_u(7'h37, rd, r[31:12]);
      5: return e_u(7'h17, rd, r[31:12]);
      6: return e_s(3'($urandom_range(0, 2)), 5'd0, rs2, {4'b0, r[5:0], 2'b0});
      7: return e_i(7'h03, (f3 == 3'd2) ? 3'd4 : 3'd2, rd, 5'd0, {4'b0, r[5:0], 2'b0});
      8: begin
        if (idx > 58) return e_i(7'h13, 3'd0, rd, rs1, r[11:0]);
        if (r[31]) return e_j(rd, 21'd8);
        return e_b((f3 == 3'd2 || f3 == 3'd3) ? 3'd0 : f3, rs1, rs2, 13'd8);
      end
      default: return {r[31:7], nop_ops[$urandom_range(0, 2)]};
    endcase
  endfunction

  task automatic test_random();
    int used;
    for (int round = 0; round < 3; round++) begin
      clear_imem();
      for (int i = 0; i < 60; i++) imem[i] = rand_ins(i);
      imem[60] = e_j(5'd0, 21'd0);
      do_reset();
      run_prog(200, 32'd240, -1, used);
      n_checks++;
      if (mpc !== 32'd240) begin n_fail++; $display("FAIL rand_halt r%0d: got pc=%h want f0", round, mpc); end
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (dut.reg_file_inst.registers[i] !== mregs[i]) begin
          n_fail++; $display("FAIL rand_reg r%0d x%0d: got %h want %h", round, i, dut.reg_file_inst.registers[i], mregs[i]);
        end
      end
      for (int i = 0; i < 64; i++) begin
        n_checks++;
        if (dmem[i] !== mdmem[i]) begin n_fail++; $display("FAIL rand_mem r%0d [%0d]: got %h want %h", round, i, dmem[i], mdmem[i]); end
      end
    end
  endtask

  task automatic test_mid_reset();
    int used;
    logic [31:0] old_val;
    logic [9:0]  idx;
    load_sum();
    do_reset();
    run_prog(500, 32'hFFFF_FFFF, 5, used);
    n_checks++;
    if (imem[mpc[9:2]][6:0] != 7'h23 || used >= 500) begin
      n_fail++; $display("FAIL mid_find_sw: got pc=%h used=%0d want store", mpc, used);
    end
    idx = mem_addr[11:2];
    old_val = dmem[idx];
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (mem_wr_sig !== 1'b0) begin n_fail++; $display("FAIL mid_store_gate: got %b want 0", mem_wr_sig); end
    @(posedge clk); #1;
    n_checks++;
    if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL mid_pc: got %h want 0", rom_addr); end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.reg_file_inst.registers[i] !== 32'h0) begin
        n_fail++; $display("FAIL mid_reg x%0d: got %h want 0", i, dut.reg_file_inst.registers[i]);
      end
    end
    n_checks++;
    if (dmem[idx] !== old_val) begin n_fail++; $display("FAIL mid_no_store: got %h want %h", dmem[idx], old_val); end
    @(negedge clk);
    reset_n = 1'b0;
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    n_checks++;
    if (rom_addr !== 32'h0) begin n_fail++; $display("FAIL mid_release_pc: got %h want 0", rom_addr); end
    run_prog(500, 32'h10, -1, used);
    n_checks++;
    if (dut.reg_file_inst.registers[29] !== 32'd55) begin n_fail++; $display("FAIL mid_rerun: got %0d want 55", dut.reg_file_inst.registers[29]); end
  endtask

  initial begin
    clear_imem();
    for (int i = 0; i < 1024; i++) dmem[i] = '0;
    test_reset();
    test_alu_mem();
    test_branch_jal();
    test_sum_recursive();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
